bcd_seg_scan: RTL
=================

# bcd_seg_scan

Time-multiplexed seven-segment display driver that sits directly downstream of the cascaded BCD counter digits. It captures a snapshot of `DIGITS` BCD nibbles once per scan frame and drives one digit position at a time on the board's common-anode display. It also handles leading-zero blanking, per-digit decimal points and invalid-code indication.

## Interface
Parameters:
- `DIGITS`, default 4: number of display positions. Legal range is 2..8.
- `PRESCALE`, default 100000: clk cycles each digit is driven. Minimum is 2.

Ports:
- `clk` in 1: system clock; all state changes on its rising edge.
- `clr` in 1: asynchronous, active-high reset.
- `enable` in 1: when 1, the prescaler and scan run; when 0, all state holds.
- `digits` in 4*DIGITS: BCD nibbles; `digits[3:0]` is the least significant digit.
- `dp_in` in DIGITS: decimal-point request per position; 1 = lit.
- `blank_lz` in 1: when 1, leading-zero blanking is enabled.
- `seg` out 7: segment drive, active-low, `seg[0]`=a … `seg[6]`=g.
- `dp` out 1: decimal point, active-low.
- `an` out DIGITS: anode select, active-low, one-hot-low.
- `frame` out 1: one-cycle pulse marking each snapshot/frame start.

## Operation
- Prescaler `pcnt` counts 0..PRESCALE-1 while `enable`=1. `tick` = (`pcnt`==PRESCALE-1).
- On `tick`, `pcnt` returns to 0 and scan index `idx` advances. After DIGITS-1, `idx` wraps to 0.
- Snapshot register `snap` (4*DIGITS) and `dp_snap` (DIGITS) load from `digits` and `dp_in` on:
  - the edge where `idx` wraps DIGITS-1→0 with `tick`; and
  - the first enabled edge after reset, via a `primed` flag cleared by `clr`.
- `frame` is 1 for exactly the cycle following each snapshot load.
- Mid-frame changes on `digits` are ignored until the next snapshot. This prevents display tearing.
- Digit decode of `snap[idx]`:
  - 0–9: standard glyphs. 0=7'b1000000, 1=7'b1111001, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000.
  - 10–15: dash, 7'b0111111.
  - Blank: 7'b1111111.
- Leading-zero blanking: with `blank_lz`=1, position k is blanked if k>0 and all `snap` positions ≥k are 0. Position 0 is never blanked. Blanked positions also force `dp`=1.
- `an[idx]`=0; all other `an` bits are 1.
- `enable`=0: `pcnt`, `idx`, `snap`, `primed` and all outputs hold their current values. `frame` is forced to 0.

## Timing
- Reset values, held asynchronously while `clr`=1:
  - `pcnt`=0, `idx`=0, `snap`=0, `dp_snap`=0, `primed`=0.
  - `an`=all 1, `seg`=7'b1111111, `dp`=1, `frame`=0.
- All outputs are registered. `seg`/`dp`/`an` reflect `idx`/`snap` with one clock of latency.
- First enabled edge after reset loads `snap` (cycle 1). Outputs show position 0 from the following edge (cycle 2).
- Each position is driven for exactly PRESCALE enabled cycles. A full frame is DIGITS×PRESCALE enabled cycles.
- `clr` asserted mid-frame: outputs go to reset values immediately. The scan restarts from position 0 with a fresh snapshot.
- `enable` deasserted on a `tick` cycle: the advance does not happen. It resumes on the next enabled `tick`.

## Structure
- Shared package `bcd_pkg` holds:
  - the segment constants (`SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_BLANK`);
  - the active-low polarity constants.
- One sub-module, `bcd_to_seg`: combinational 4-bit → 7-bit decoder including the dash case. It is reused by any later display block.
- The top module holds the prescaler, scan index, snapshot, blanking logic and output registers.

## Test plan
All scenarios use PRESCALE=4, DIGITS=4.

- **Reset:** assert `clr` mid-scan → `an`=4'b1111, `seg`=7'b1111111, `dp`=1 in the same cycle. After release, `frame` pulses once. `an`=4'b1110 for 4 cycles, then 4'b1101.
- **Plain scan:** `digits`=16'h1987, `blank_lz`=0, `dp_in`=4'b0100 → per position `seg` sequence is 7'b1111000 (7), 7'b0000000 (8), 7'b0010000 (9), 7'b1111001 (1). `dp`=0 only while `an`=4'b1011. `frame` period is 16 cycles.
- **Leading-zero blanking:** `digits`=16'h0070, `blank_lz`=1 → positions 3 and 2 show 7'b1111111, position 1 shows 7. With `digits`=16'h0000, position 0 still shows 7'b1000000.
- **Invalid code:** `digits`=16'h00A5 → position 1 shows 7'b0111111, position 0 shows 7'b0010010 (5).
- **Snapshot isolation:** change `digits` from 16'h0001 to 16'h0009 while `an`=4'b1101 → position 0 continues to show 1 until after the next `frame` pulse, then shows 9.
- **Enable hold:** drop `enable` for 10 cycles during position 2 → `an`, `seg` and `dp` hold. Position 2 completes its remaining cycles after `enable` returns.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared seven-segment glyphs and display polarity constants
// Segment order is {g,f,e,d,c,b,a}; every glyph is active-low.
package bcd_pkg;
    localparam logic SEG_ON  = 1'b0;
    localparam logic SEG_OFF = 1'b1;
    localparam logic AN_ON   = 1'b0;
    localparam logic AN_OFF  = 1'b1;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD to active-low seven-segment decoder
// i_bcd : 4-bit code; 10..15 decode to a dash
// o_seg : active-low segments, o_seg[0]=a .. o_seg[6]=g
module bcd_to_seg
    import bcd_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);
    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: time-multiplexed seven-segment driver with per-frame snapshot
// clk, clr (async active-high) ; enable gates all state
// digits/dp_in : BCD nibbles and decimal points, captured once per frame
// blank_lz     : leading-zero blanking enable
// seg/dp/an    : registered active-low display drive ; frame : snapshot pulse
module bcd_seg_scan
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 100000
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                enable,
    input  logic [4*DIGITS-1:0] digits,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                blank_lz,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   an,
    output logic                frame
);
    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);

    logic [PW-1:0]       r_pcnt;
    logic [IW-1:0]       r_idx;
    logic [4*DIGITS-1:0] r_snap;
    logic [DIGITS-1:0]   r_dp_snap;
    logic                r_primed;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame;

    logic                w_tick;
    logic                w_wrap;
    logic                w_load;
    logic [3:0]          w_nib;
    logic [6:0]          w_seg;
    logic [DIGITS-1:0]   w_lz;
    logic                w_blank;
    logic [DIGITS-1:0]   w_an;

    assign w_tick  = r_pcnt == PW'(PRESCALE - 1);
    assign w_wrap  = w_tick && r_idx == IW'(DIGITS - 1);
    assign w_load  = !r_primed || w_wrap;
    assign w_nib   = r_snap[{r_idx, 2'b00} +: 4];
    assign w_blank = blank_lz && r_idx != '0 && w_lz[r_idx];
    assign w_an    = ~(DIGITS'(1) << r_idx);

    // w_lz[k]: snapshot positions k and above are all zero
    always_comb begin
        logic w_run;
        w_run = 1'b1;
        w_lz  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_run   = w_run && r_snap[4*k +: 4] == 4'd0;
            w_lz[k] = w_run;
        end
    end

    bcd_to_seg u_dec (
        .i_bcd (w_nib),
        .o_seg (w_seg)
    );

    // The priming edge only captures the snapshot; counting starts on the
    // next edge so position 0 gets its full PRESCALE cycles on screen.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pcnt    <= '0;
            r_idx     <= '0;
            r_snap    <= '0;
            r_dp_snap <= '0;
            r_primed  <= 1'b0;
            r_seg     <= SEG_BLANK;
            r_dp      <= SEG_OFF;
            r_an      <= {DIGITS{AN_OFF}};
            r_frame   <= 1'b0;
        end else begin
            r_frame <= enable && w_load;
            if (enable) begin
                r_primed <= 1'b1;
                if (w_load) begin
                    r_snap    <= digits;
                    r_dp_snap <= dp_in;
                end
                if (r_primed) begin
                    r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
                    if (w_tick)
                        r_idx <= w_wrap ? '0 : r_idx + 1'b1;
                    r_seg <= w_blank ? SEG_BLANK : w_seg;
                    r_dp  <= (w_blank || !r_dp_snap[r_idx]) ? SEG_OFF : SEG_ON;
                    r_an  <= w_an;
                end
            end
        end
    end

    assign seg   = r_seg;
    assign dp    = r_dp;
    assign an    = r_an;
    assign frame = r_frame;
endmodule
